// File: rtl/dnn_argmax_classifier.sv
// Serial argmax over a parallel score vector with a valid/ready result handshake.
// Optional runner-up class and margin outputs are enabled by defining ARGMAX_RUNNER_UP_EN.
module dnn_argmax_classifier #(
  parameter int NumClasses = 2,
  parameter int BitSize    = 32,
  parameter bit Signed     = 1'b1,
  parameter int IdxW       = (NumClasses > 1) ? $clog2(NumClasses) : 1
) (
  input  logic                               clk,
  input  logic                               res,
  input  logic                               in_valid,
  input  logic [NumClasses-1:0][BitSize-1:0] in_data,
  input  logic                               in_done,
  output logic                               in_ready,
  output logic                               out_valid,
  output logic [IdxW-1:0]                    out_class,
  output logic [BitSize-1:0]                 out_score,
  output logic                               out_last,
  input  logic                               out_ready,
  output logic                               out_overrun
`ifdef ARGMAX_RUNNER_UP_EN
  ,
  output logic [IdxW-1:0]                    out_class2,
  output logic [BitSize-1:0]                 out_margin
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumClasses - 1);

  logic [1:0]                        state_q, state_d;
  logic [NumClasses-1:0][BitSize-1:0] vec_q, vec_d;
  logic                              done_q, done_d;
  logic [IdxW-1:0]                   i_q, i_d;
  logic [IdxW-1:0]                   idx_q, idx_d;
  logic [BitSize-1:0]                best_q, best_d;
  logic                              out_valid_q, out_valid_d;
  logic [IdxW-1:0]                   out_class_q, out_class_d;
  logic [BitSize-1:0]                out_score_q, out_score_d;
  logic                              out_last_q, out_last_d;
  logic                              overrun_q, overrun_d;
  logic [BitSize-1:0]                elem;
  logic                              new_max;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [IdxW-1:0]                   idx2_q, idx2_d;
  logic [BitSize-1:0]                sec_q, sec_d;
  logic [IdxW-1:0]                   out_class2_q, out_class2_d;
  logic [BitSize-1:0]                out_margin_q, out_margin_d;
`endif

  function automatic logic gt(input logic [BitSize-1:0] a, input logic [BitSize-1:0] b);
    if (Signed) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  // Decoded mux keeps the element select in range for any NumClasses.
  always_comb begin
    elem = '0;
    for (int unsigned k = 0; k < NumClasses; k++) begin
      if (i_q == IdxW'(k)) elem = vec_q[k];
    end
  end

  assign new_max  = gt(elem, best_q);
  assign in_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    done_d      = done_q;
    i_d         = i_q;
    idx_d       = idx_q;
    best_d      = best_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    out_last_d  = out_last_q;
    overrun_d   = overrun_q | (in_valid & ~in_ready);
`ifdef ARGMAX_RUNNER_UP_EN
    idx2_d       = idx2_q;
    sec_d        = sec_q;
    out_class2_d = out_class2_q;
    out_margin_d = out_margin_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          vec_d  = in_data;
          done_d = in_done;
          best_d = in_data[0];
          idx_d  = '0;
          i_d    = IdxW'(1);
`ifdef ARGMAX_RUNNER_UP_EN
          sec_d  = '0;
          idx2_d = '0;
`endif
          if (NumClasses == 1) begin
            state_d     = ST_RESULT;
            out_valid_d = 1'b1;
            out_class_d = '0;
            out_score_d = in_data[0];
            out_last_d  = in_done;
`ifdef ARGMAX_RUNNER_UP_EN
            out_class2_d = '0;
            out_margin_d = '0;
`endif
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (new_max) begin
          best_d = elem;
          idx_d  = i_q;
        end
`ifdef ARGMAX_RUNNER_UP_EN
        // Element 1 always seeds second place unless it displaces the best.
        if (new_max) begin
          sec_d  = best_q;
          idx2_d = idx_q;
        end else if ((i_q == IdxW'(1)) || gt(elem, sec_q)) begin
          sec_d  = elem;
          idx2_d = i_q;
        end
`endif
        if (i_q == LastIdx) begin
          state_d     = ST_RESULT;
          out_valid_d = 1'b1;
          out_class_d = idx_d;
          out_score_d = best_d;
          out_last_d  = done_q;
`ifdef ARGMAX_RUNNER_UP_EN
          out_class2_d = idx2_d;
          out_margin_d = best_d - sec_d;
`endif
        end else begin
          i_d = i_q + IdxW'(1);
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      done_q      <= 1'b0;
      i_q         <= '0;
      idx_q       <= '0;
      best_q      <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ARGMAX_RUNNER_UP_EN
      idx2_q       <= '0;
      sec_q        <= '0;
      out_class2_q <= '0;
      out_margin_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      done_q      <= done_d;
      i_q         <= i_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
`ifdef ARGMAX_RUNNER_UP_EN
      idx2_q       <= idx2_d;
      sec_q        <= sec_d;
      out_class2_q <= out_class2_d;
      out_margin_q <= out_margin_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign out_class   = out_class_q;
  assign out_score   = out_score_q;
  assign out_last    = out_last_q;
  assign out_overrun = overrun_q;
`ifdef ARGMAX_RUNNER_UP_EN
  assign out_class2  = out_class2_q;
  assign out_margin  = out_margin_q;
`endif

endmodule
